// File: rtl/mc_chroma_ref_buf.sv
// ---------------------------------------------------------------------------
// mc_chroma_ref_buf
//   Chroma reference window buffer for motion compensation. Holds a
//   2 (U/V) x 64 row x 64 pixel window split across 8 pixel banks so that
//   any 8 horizontally adjacent pixels, aligned or not, come back in a
//   single read with one cycle of latency. Reads that run past the right
//   edge repeat pixel 63.
//
// Ports
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   load_start_i   pulse: begin loading a new window (ignored during a load)
//   load_valid_i   load beat valid
//   load_data_i    8 adjacent pixels, p0 in the MSBs
//   load_ready_o   a beat is accepted this cycle when load_valid_i is set
//   load_done_o    one-cycle pulse after the last beat has been written
//   buf_ready_o    window is complete and readable
//   ref_rden_i     read enable
//   ref_idx_x_i    x of the leftmost pixel, 0..63
//   ref_idx_y_i    row, 0..63
//   ref_sel_i      0 = U, 1 = V
//   ref_pel_o      8 pixels, p0 in the MSBs, valid the cycle after a read
//   ref_err_o      the read one cycle earlier was issued while not ready
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no valid window; reads are rejected
// LOAD  | accepting 1024 beats, ordered col, then row, then component
// READY | window complete; reads are served
// ---------------------------------------------------------------------------
module mc_chroma_ref_buf #(
  // Pixel width of the encoder pixel type.
  localparam int PIXEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  input  logic [8*PIXEL_WIDTH-1:0] load_data_i,
  output logic                     load_ready_o,
  output logic                     load_done_o,
  output logic                     buf_ready_o,
  input  logic                     ref_rden_i,
  input  logic [5:0]               ref_idx_x_i,
  input  logic [5:0]               ref_idx_y_i,
  input  logic                     ref_sel_i,
  output logic [8*PIXEL_WIDTH-1:0] ref_pel_o,
  output logic                     ref_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [9:0] beat_cnt;
  logic       wr_en;
  logic       rd_en;
  logic       last_beat;

  // Registered read context used to rotate and clamp the bank outputs.
  logic [5:0] x_q;
  logic       zero_q;

  logic [7:0][PIXEL_WIDTH-1:0] bank_bus;

  assign wr_en     = load_valid_i && (state == LOAD);
  assign rd_en     = ref_rden_i && (state == READY);
  assign last_beat = wr_en && (beat_cnt == 10'd1023);

  assign load_ready_o = (state == LOAD);
  assign buf_ready_o  = (state == READY);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start_i) state_nxt = LOAD;
      LOAD:    if (last_beat)    state_nxt = READY;
      READY:   if (load_start_i) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Beat counter and load-done pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt    <= '0;
      load_done_o <= 1'b0;
    end else begin
      load_done_o <= last_beat;
      if (state != LOAD && state_nxt == LOAD) beat_cnt <= '0;
      else if (wr_en)                         beat_cnt <= beat_cnt + 10'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel banks. Bank b holds every pixel with x%8 == b. For a read at x,
  // banks below x%8 belong to the next 8-pixel word; the word index can
  // wrap past 7 only for lanes that the edge clamp replaces anyway.
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < 8; b++) begin : g_bank
    logic [PIXEL_WIDTH-1:0] mem [1024];
    logic [PIXEL_WIDTH-1:0] rd_q;
    logic [2:0]             word;
    logic [9:0]             rd_addr;

    always_comb begin
      word    = ref_idx_x_i[5:3] + ((3'(b) < ref_idx_x_i[2:0]) ? 3'd1 : 3'd0);
      rd_addr = {ref_sel_i, ref_idx_y_i, word};
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[beat_cnt] <= load_data_i[(7-b)*PIXEL_WIDTH +: PIXEL_WIDTH];
      if (rd_en) rd_q <= mem[rd_addr];
    end

    assign bank_bus[b] = rd_q;
  end

  // ---------------------------------------------------------------------
  // Read status
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q       <= '0;
      zero_q    <= 1'b1;
      ref_err_o <= 1'b0;
    end else begin
      ref_err_o <= ref_rden_i && (state != READY);
      if (ref_rden_i) zero_q <= (state != READY);
      if (rd_en)      x_q    <= ref_idx_x_i;
    end
  end

  // ---------------------------------------------------------------------
  // Rotate by x%8, then clamp. Pixel 63 always sits in bank 7 at word 7,
  // which is exactly what bank 7 fetched whenever a lane runs past 63.
  // All inputs here are registers, so the output holds between reads.
  // ---------------------------------------------------------------------
  always_comb begin
    logic [6:0] xsum;
    ref_pel_o = '0;
    xsum      = '0;
    for (int i = 0; i < 8; i++) begin
      xsum = {1'b0, x_q} + 7'(i);
      if (zero_q)
        ref_pel_o[(7-i)*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
      else if (xsum > 7'd63)
        ref_pel_o[(7-i)*PIXEL_WIDTH +: PIXEL_WIDTH] = bank_bus[7];
      else
        ref_pel_o[(7-i)*PIXEL_WIDTH +: PIXEL_WIDTH] = bank_bus[3'(x_q[2:0] + 3'(i))];
    end
  end

endmodule

// File: tb/tb_mc_chroma_ref_buf.sv
// ---------------------------------------------------------------------------
// tb_mc_chroma_ref_buf
//   Directed bench for the chroma reference buffer: reset state, rejected
//   reads, a full window load with random valid stalls, aligned, unaligned
//   and edge-clamped reads, the READY->LOAD handover and a reset-aborted
//   reload.
// ---------------------------------------------------------------------------
module tb_mc_chroma_ref_buf;

  logic        clk;
  logic        rstn;
  logic        load_start_i;
  logic        load_valid_i;
  logic [63:0] load_data_i;
  logic        load_ready_o;
  logic        load_done_o;
  logic        buf_ready_o;
  logic        ref_rden_i;
  logic [5:0]  ref_idx_x_i;
  logic [5:0]  ref_idx_y_i;
  logic        ref_sel_i;
  logic [63:0] ref_pel_o;
  logic        ref_err_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  mc_chroma_ref_buf dut (
    .clk          (clk),
    .rstn         (rstn),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .buf_ready_o  (buf_ready_o),
    .ref_rden_i   (ref_rden_i),
    .ref_idx_x_i  (ref_idx_x_i),
    .ref_idx_y_i  (ref_idx_y_i),
    .ref_sel_i    (ref_sel_i),
    .ref_pel_o    (ref_pel_o),
    .ref_err_o    (ref_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (load_done_o) done_cnt++;

  // pixel(c,y,x) = (x + y + c*128) & 255
  function automatic logic [63:0] beat_data(input int b);
    logic [63:0] d;
    int c, y, col, p;
    c = (b >> 9) & 1;
    y = (b >> 3) & 63;
    col = b & 7;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      p = (col * 8 + i + y + c * 128) & 255;
      d[(7-i)*8 +: 8] = p[7:0];
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic sel, input int y, input int x);
    ref_rden_i  = 1'b1;
    ref_sel_i   = sel;
    ref_idx_y_i = 6'(y);
    ref_idx_x_i = 6'(x);
    step();
    ref_rden_i  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    load_start_i = 0; load_valid_i = 0; load_data_i = '0;
    ref_rden_i = 0; ref_idx_x_i = '0; ref_idx_y_i = '0; ref_sel_i = 0;
    repeat (3) step();
    tests_run++;
    if ({load_ready_o, load_done_o, buf_ready_o, ref_err_o} !== 4'b0000 || ref_pel_o !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b done=%b buf=%b err=%b pel=%h, want all 0",
               load_ready_o, load_done_o, buf_ready_o, ref_err_o, ref_pel_o);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_read_idle();
    issue_read(1'b0, 0, 0);
    tests_run++;
    if (ref_err_o !== 1'b1 || ref_pel_o !== 64'd0) begin
      tests_failed++;
      $display("FAIL idle_read: err=%b pel=%h, want err=1 pel=0", ref_err_o, ref_pel_o);
    end
    step();
    tests_run++;
    if (ref_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_err_clear: err=%b, want 0", ref_err_o);
    end
  endtask

  task automatic test_full_load();
    int b = 0, cycles = 0;
    bit v, acc, rd;
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
    tests_run++;
    if (load_ready_o !== 1'b1 || buf_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_entry: load_ready=%b buf_ready=%b, want 1 0", load_ready_o, buf_ready_o);
    end
    while (b < 1024 && cycles < 6000) begin
      v = ($urandom_range(0, 3) != 0);
      rd = (b == 300 && !rd);
      load_valid_i = v;
      load_data_i  = beat_data(b);
      load_start_i = (b == 600);
      ref_rden_i   = rd;
      acc = v && load_ready_o;
      step();
      cycles++;
      ref_rden_i = 1'b0;
      if (rd) begin
        tests_run++;
        if (ref_err_o !== 1'b1 || ref_pel_o !== 64'd0) begin
          tests_failed++;
          $display("FAIL load_read: err=%b pel=%h, want err=1 pel=0", ref_err_o, ref_pel_o);
        end
      end
      if (acc) begin
        b++;
        if (b == 1024) begin
          tests_run++;
          if (load_done_o !== 1'b1 || buf_ready_o !== 1'b1 || load_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_done: done=%b buf=%b load_ready=%b, want 1 1 0",
                     load_done_o, buf_ready_o, load_ready_o);
          end
        end
      end
    end
    load_valid_i = 1'b0;
    load_start_i = 1'b0;
    tests_run++;
    if (b != 1024) begin
      tests_failed++;
      $display("FAIL load_budget: beats=%0d, want 1024", b);
    end
    step();
    tests_run++;
    if (load_done_o !== 1'b0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL done_once: done=%b count=%0d, want 0 1", load_done_o, done_cnt);
    end
  endtask

  task automatic test_reads();
    logic        sel [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          ys  [7] = '{5, 0, 2, 10, 63, 63, 63};
    int          xs  [7] = '{16, 3, 60, 7, 57, 60, 63};
    logic [63:0] exp [7] = '{64'h95969798999A9B9C, 64'h030405060708090A,
                             64'h3E3F404141414141, 64'h1112131415161718,
                             64'hF8F9FAFBFCFDFEFE, 64'hFBFCFDFEFEFEFEFE,
                             64'hFEFEFEFEFEFEFEFE};
    for (int k = 0; k < 7; k++) begin
      issue_read(sel[k], ys[k], xs[k]);
      tests_run++;
      if (ref_pel_o !== exp[k] || ref_err_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL read_%0d: pel=%h err=%b, want pel=%h err=0", k, ref_pel_o, ref_err_o, exp[k]);
      end
    end
    ref_idx_x_i = 6'd0;
    ref_idx_y_i = 6'd9;
    step();
    tests_run++;
    if (ref_pel_o !== 64'hFEFEFEFEFEFEFEFE || ref_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_hold: pel=%h err=%b, want FEFEFEFEFEFEFEFE err=0", ref_pel_o, ref_err_o);
    end
  endtask

  task automatic test_back_to_back();
    issue_read(1'b0, 1, 8);
    issue_read(1'b1, 0, 1);
    tests_run++;
    if (ref_pel_o !== 64'h8182838485868788) begin
      tests_failed++;
      $display("FAIL b2b_read: pel=%h, want 8182838485868788", ref_pel_o);
    end
  endtask

  task automatic test_reload_abort();
    int b = 0, cycles = 0;
    int done_before;
    done_before = done_cnt;
    load_start_i = 1'b1;
    issue_read(1'b0, 0, 3);
    load_start_i = 1'b0;
    tests_run++;
    if (ref_pel_o !== 64'h030405060708090A || ref_err_o !== 1'b0 ||
        buf_ready_o !== 1'b0 || load_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL handover: pel=%h err=%b buf=%b load_ready=%b, want 030405060708090A 0 0 1",
               ref_pel_o, ref_err_o, buf_ready_o, load_ready_o);
    end
    while (b < 501 && cycles < 3000) begin
      load_valid_i = ($urandom_range(0, 1) == 1);
      load_data_i  = beat_data(b) ^ 64'hFFFF_FFFF_FFFF_FFFF;
      if (load_valid_i && load_ready_o) b++;
      step();
      cycles++;
    end
    load_valid_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if (load_ready_o !== 1'b0 || buf_ready_o !== 1'b0 || load_done_o !== 1'b0 || b != 501) begin
      tests_failed++;
      $display("FAIL abort: load_ready=%b buf=%b done=%b beats=%0d, want 0 0 0 501",
               load_ready_o, buf_ready_o, load_done_o, b);
    end
    step();
    rstn = 1'b1;
    repeat (5) step();
    tests_run++;
    if (load_ready_o !== 1'b0 || buf_ready_o !== 1'b0 || done_cnt != done_before) begin
      tests_failed++;
      $display("FAIL abort_idle: load_ready=%b buf=%b done_count=%0d, want 0 0 %0d",
               load_ready_o, buf_ready_o, done_cnt, done_before);
    end
    issue_read(1'b0, 0, 0);
    tests_run++;
    if (ref_err_o !== 1'b1 || ref_pel_o !== 64'd0) begin
      tests_failed++;
      $display("FAIL abort_read: err=%b pel=%h, want err=1 pel=0", ref_err_o, ref_pel_o);
    end
  endtask

  initial begin
    test_reset();
    test_read_idle();
    test_full_load();
    test_reads();
    test_back_to_back();
    test_reload_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_chroma_ref_buf.md
MC_CHROMA_REF_BUF -- requirements
Module: mc_chroma_ref_buf

Interface
REQ-001 Parameters: none; the pixel width is `PIXEL_WIDTH from enc_defines.v (8 bits).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 load_start_i  input  1  one-cycle pulse that starts a full window load.
REQ-005 load_valid_i  input  1  load beat valid.
REQ-006 load_data_i  input  8*`PIXEL_WIDTH  8 horizontally adjacent pixels; p0 is in the MSBs.
REQ-007 load_ready_o  output  1  buffer accepts a beat this cycle.
REQ-008 load_done_o  output  1  one-cycle pulse after the last beat is written.
REQ-009 buf_ready_o  output  1  window is complete and readable.
REQ-010 ref_rden_i  input  1  reference read enable from the chroma MC.
REQ-011 ref_idx_x_i  input  6  x index of the leftmost pixel, 0..63.
REQ-012 ref_idx_y_i  input  6  row index, 0..63.
REQ-013 ref_sel_i  input  1  component select: 0=U, 1=V.
REQ-014 ref_pel_o  output  8*`PIXEL_WIDTH  8 reference pixels; p0 is in the MSBs.
REQ-015 ref_err_o  output  1  the read one cycle earlier was issued while the buffer was not READY.

Function
REQ-016 Storage SHALL be 2 components x 64 rows x 64 pixels, split into 8 banks; pixel (c,y,x) SHALL be in bank x%8 at address {c, y, x/8}, 1024 entries per bank.
REQ-017 The FSM SHALL have three states: IDLE, LOAD and READY.
REQ-018 FSM transitions SHALL be:
- IDLE->LOAD and READY->LOAD on load_start_i.
- LOAD->READY on acceptance of beat 1023.
- load_start_i during LOAD SHALL be ignored.
REQ-019 load_ready_o SHALL be 1 exactly when state==LOAD.
REQ-020 A beat SHALL be accepted when load_valid_i & load_ready_o.
REQ-021 A 10-bit beat counter {c, y[5:0], col[2:0]} SHALL start at 0 on entry to LOAD and increment per accepted beat, so that col is fastest, then y, then c.
REQ-022 Beat pixel i SHALL be written to bank i at address {c, y, col}.
REQ-023 load_done_o SHALL pulse in the cycle after beat 1023 is accepted, coincident with the first cycle of READY.
REQ-024 buf_ready_o SHALL be 1 exactly when state==READY.
REQ-025 Entering LOAD from READY SHALL deassert buf_ready_o in the next cycle; old contents are progressively overwritten.
REQ-026 Read latency SHALL be 1 cycle: a read issued in cycle N SHALL have ref_pel_o registered and valid in cycle N+1.
REQ-027 For a read in READY, output pixel i (i=0..7) SHALL equal stored pixel (ref_sel_i, ref_idx_y_i, min(ref_idx_x_i+i, 63)); the right edge is replicated.
REQ-028 Unaligned reads SHALL be served in one cycle:
- Bank b address = {sel, y, (x+((b-x)mod 8))/8}.
- Rotate bank outputs by x%8.
- Apply the clamp after rotation.
REQ-029 A read issued when state!=READY SHALL return ref_pel_o=0 and pulse ref_err_o=1 in cycle N+1; no storage is modified.
REQ-030 When ref_rden_i=0, ref_pel_o SHALL hold its last value and ref_err_o SHALL be 0.
REQ-031 In the cycle of the READY->LOAD transition, a read SHALL still be served from the old contents.
REQ-032 The beat counter SHALL wrap only through the FSM; no write SHALL occur outside LOAD.

Reset
REQ-033 On rstn low, outputs SHALL reset as follows:
- state=IDLE, beat counter=0.
- load_ready_o=0, load_done_o=0, buf_ready_o=0.
- ref_pel_o=0, ref_err_o=0.
REQ-034 Memory contents are not reset; reads before the first completed load are rejected per REQ-029.
REQ-035 Reset asserted mid-LOAD SHALL abort the load: state returns to IDLE and a new load_start_i is required.

Verification
REQ-036 Full load: pulse load_start_i, then 1024 beats with pixel(c,y,x) = (x+y+c*128)&255 -> load_done_o pulses once at the cycle after beat 1023; buf_ready_o=1.
REQ-037 Aligned read: sel=1, y=5, x=16 -> next cycle ref_pel_o = {149..156} (p0=149).
REQ-038 Unaligned read: sel=0, y=0, x=3 -> next cycle ref_pel_o = {3,4,5,6,7,8,9,10}, with the read spanning banks 3..7 and 0..2.
REQ-039 Edge clamp: sel=0, y=2, x=60 -> ref_pel_o = {62,63,64,65,65,65,65,65}.
REQ-040 Read while not ready: ref_rden_i in IDLE and again mid-LOAD -> ref_pel_o=0 and ref_err_o=1 one cycle later, with the load beat count unaffected.
REQ-041 Stall and abort:
- Toggle load_valid_i randomly -> no beat lost or duplicated.
- Assert rstn=0 after beat 500 -> IDLE, load_ready_o=0, and no load_done_o.
